// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter that shares one 8:1 mux among 8 requesters. Requester n
//   owns mux input I[n]. The current owner index drives the mux select S, and
//   the mux output Y is registered together with its source index.
//
//   Optional feature macro: MUX_ARB_TIMEOUT_EN
//     defined   -> a grant is revoked after MAX_HOLD cycles; timeout pulses
//     undefined -> no tenure limit; timeout is constant 0
//
// Parameters
//   MAX_HOLD   grant tenure limit in cycles (1..15), timeout build only
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   level requests, held until granted and served
//   done       single-cycle release pulse from the current owner
//   Y          mux output (combinational from I and S)
//   S[2:0]     mux select = index of current owner (registered)
//   gnt[7:0]   one-hot grant, zero when idle
//   gnt_valid  a grant is active
//   samp_y     registered Y of the owner
//   samp_src   owner index samp_y was taken from
//   samp_vld   samp_y/samp_src valid
//   timeout    1-cycle pulse: grant revoked by the tenure limit
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       Y,
  output logic [2:0] S,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       samp_y,
  output logic [2:0] samp_src,
  output logic       samp_vld,
  output logic       timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be in 1..15");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [2:0] ptr_q, ptr_d;
  logic       timeout_q, timeout_d;
  logic       samp_y_q;
  logic [2:0] samp_src_q;
  logic       samp_vld_q;

  logic       limit_hit;
  logic       rel;
  logic [2:0] scan_base;
  logic       found;
  logic [2:0] pick;

  // First set bit of r scanning base, base+1, ... (mod 8). Iterating from the
  // far end lets the nearest hit overwrite the others.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      idx = base + 3'(i - 1);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX_ARB_TIMEOUT_EN
  logic [3:0] tenure_q, tenure_d;

  assign limit_hit = (state_q == GRANT) && (tenure_q == 4'(MAX_HOLD - 1));

  always_comb begin
    tenure_d = tenure_q;
    if (state_d == GRANT && (state_q == IDLE || rel)) begin
      tenure_d = '0;
    end else if (state_q == GRANT && tenure_q != 4'hF) begin
      tenure_d = tenure_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tenure_q <= '0;
    else        tenure_q <= tenure_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign rel = (state_q == GRANT) && (done || !req[s_q] || limit_hit);

  // On release the scan starts just past the old owner, which is then
  // naturally visited last; in IDLE ptr already holds that position.
  assign scan_base = (state_q == GRANT) ? s_q + 3'd1 : ptr_q;
  assign {found, pick} = rr_pick(req, scan_base);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          s_d     = pick;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d     = s_q + 3'd1;
          timeout_d = limit_hit && !done && req[s_q];
          if (found) s_d = pick;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      ptr_q      <= '0;
      timeout_q  <= 1'b0;
      samp_y_q   <= 1'b0;
      samp_src_q <= '0;
      samp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
      if (state_q == GRANT) begin
        samp_y_q   <= Y;
        samp_src_q <= s_q;
        samp_vld_q <= 1'b1;
      end else begin
        samp_vld_q <= 1'b0;
      end
    end
  end

  assign S         = s_q;
  assign gnt_valid = (state_q == GRANT);
  assign gnt       = gnt_valid ? (8'b1 << s_q) : '0;
  assign samp_y    = samp_y_q;
  assign samp_src  = samp_src_q;
  assign samp_vld  = samp_vld_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter with a behavioural reference model that
//   is compared against every output on every falling clock edge, plus literal
//   expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       Y;
  logic [7:0] I_vec;
  logic [2:0] S;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       samp_y;
  logic [2:0] samp_src;
  logic       samp_vld;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .Y         (Y),
    .S         (S),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .samp_y    (samp_y),
    .samp_src  (samp_src),
    .samp_vld  (samp_vld),
    .timeout   (timeout)
  );

  // The shared 8:1 mux itself.
  assign Y = I_vec[S];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_own = -1;   // owner index, -1 when idle
  int       m_ptr = 0;
  int       m_ten = 0;
  bit [2:0] m_S   = '0;
  bit       m_sy  = 1'b0;
  bit [2:0] m_ss  = '0;
  bit       m_sv  = 1'b0;
  bit       m_to  = 1'b0;

  function automatic int first_from(input logic [7:0] r, input int base);
    for (int k = 0; k < 8; k++) begin
      if (r[(base + k) % 8]) return (base + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_ten = 0; m_S = '0;
      m_sy = 1'b0; m_ss = '0; m_sv = 1'b0; m_to = 1'b0;
    end else begin
      bit lim;
      if (m_own >= 0) begin
        m_sy = I_vec[m_own];
        m_ss = 3'(m_own);
        m_sv = 1'b1;
      end else begin
        m_sv = 1'b0;
      end
      m_to = 1'b0;
      if (m_own < 0) begin
        m_own = first_from(req, m_ptr);
        m_ten = 0;
      end else begin
`ifdef MUX_ARB_TIMEOUT_EN
        lim = (m_ten == int'(MAX_HOLD) - 1);
`else
        lim = 1'b0;
`endif
        if (done || !req[m_own] || lim) begin
          m_to  = lim && !done && req[m_own];
          m_ptr = (m_own + 1) % 8;
          m_own = first_from(req, m_ptr);
          m_ten = 0;
        end else if (m_ten < 15) begin
          m_ten = m_ten + 1;
        end
      end
      if (m_own >= 0) m_S = 3'(m_own);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("S",         32'(S),         32'(m_S));
      chk("gnt",       32'(gnt),       (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
      chk("gnt_valid", 32'(gnt_valid), 32'(m_own >= 0));
      chk("samp_y",    32'(samp_y),    32'(m_sy));
      chk("samp_src",  32'(samp_src),  32'(m_ss));
      chk("samp_vld",  32'(samp_vld),  32'(m_sv));
      chk("timeout",   32'(timeout),   32'(m_to));
    end
  end

  // Advance one edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_S",   32'(S),         32'd0);
    chk("async_gnt", 32'(gnt),       32'd0);
    chk("async_gv",  32'(gnt_valid), 32'd0);
    chk("async_sv",  32'(samp_vld),  32'd0);
    chk("async_to",  32'(timeout),   32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    I_vec = 8'h00;
    tick(); tick();
    chk("rst_S",   32'(S),         32'd0);
    chk("rst_gnt", 32'(gnt),       32'd0);
    chk("rst_gv",  32'(gnt_valid), 32'd0);
    chk("rst_sv",  32'(samp_vld),  32'd0);
    chk("rst_to",  32'(timeout),   32'd0);
    req   = 8'h00;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Single request then release.
    req = 8'h04;
    tick();
    chk("single_S",   32'(S),   32'd2);
    chk("single_gnt", 32'(gnt), 32'h04);
    req = 8'h00; done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_rel_gnt", 32'(gnt),       32'h00);
    chk("single_rel_gv",  32'(gnt_valid), 32'd0);
    chk("single_ptr",     32'(m_ptr),     32'd3);
    chk("single_samp_vld", 32'(samp_vld), 32'd1);
    chk("single_samp_src", 32'(samp_src), 32'd2);
    tick();
    chk("single_samp_off", 32'(samp_vld), 32'd0);

    // Rotation from ptr=0 with done every second cycle.
    mid_reset();
    req = 8'hFF;
    tick();
    chk("rot_first", 32'(S), 32'd0);
    for (int i = 0; i < 8; i++) begin
      done = 1'b0;
      tick();
      chk("rot_hold", 32'(S), 32'(i));
      done = 1'b1;
      tick();
      chk("rot_next", 32'(S),         32'((i + 1) % 8));
      chk("rot_gv",   32'(gnt_valid), 32'd1);
    end
    req = 8'h00; done = 1'b1;
    tick();
    done = 1'b0;
    chk("rot_idle", 32'(gnt_valid), 32'd0);

    // Sampling path.
    I_vec = 8'b0010_0000;
    req   = 8'h20;
    tick();
    chk("samp_S", 32'(S), 32'd5);
    tick();
    chk("samp_y_lit",   32'(samp_y),   32'd1);
    chk("samp_src_lit", 32'(samp_src), 32'd5);
    chk("samp_vld_lit", 32'(samp_vld), 32'd1);
    req = 8'h00;
    tick();
    I_vec = 8'h00;
    tick();

    // Tenure limit: ptr is 6, so requester 0 wins over 3.
    req = 8'h09;
    tick();
    chk("to_S0", 32'(S), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_hold", 32'(S),       32'd0);
      chk("to_low",  32'(timeout), 32'd0);
    end
    tick();
`ifdef MUX_ARB_TIMEOUT_EN
    chk("to_S3",    32'(S),       32'd3);
    chk("to_pulse", 32'(timeout), 32'd1);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 6; i++) begin
      chk("noto_S",  32'(S),       32'd0);
      chk("noto_to", 32'(timeout), 32'd0);
      tick();
    end
`endif
    req = 8'h00;
    tick(); tick();

    // Async reset in the middle of a grant to requester 6.
    req = 8'h40;
    tick();
    chk("ar_S6", 32'(S), 32'd6);
    mid_reset();
    chk("ar_ptr", 32'(m_ptr), 32'd0);
    tick();
    chk("ar_regrant_S",   32'(S),   32'd6);
    chk("ar_regrant_gnt", 32'(gnt), 32'h40);
    req = 8'h00;
    tick();

    // Mixed traffic sweep, checked by the model on every cycle.
    for (int i = 0; i < 300; i++) begin
      req   = 8'($urandom);
      done  = ($urandom_range(0, 3) == 0);
      I_vec = 8'($urandom);
      tick();
    end
    req = 8'h00; done = 1'b0;
    tick(); tick();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
